axis_frame_rr_arb: RTL and testbench
====================================

AXIS_FRAME_RR_ARB -- requirements
Module: axis_frame_rr_arb

Interface
REQ-001 The block SHALL have parameter S_COUNT, default 4, giving the number of requester input streams (2..16).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 64, giving the tdata width per stream.
REQ-003 The block SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8, giving the tkeep width per stream.
REQ-004 The block SHALL have parameter USER_WIDTH, default 1, giving the tuser width per stream.
REQ-005 The block SHALL have parameter ID_WIDTH, default $clog2(S_COUNT), giving the output tid width, which carries the granted port index.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock, all logic on the rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have ports s_axis_tdata, tkeep, tlast and tuser as inputs, widths S_COUNT*DATA_WIDTH, S_COUNT*KEEP_WIDTH, S_COUNT and S_COUNT*USER_WIDTH, port i at slice i.
REQ-009 The block SHALL have port s_axis_tvalid, input, S_COUNT bits, and port s_axis_tready, output, S_COUNT bits: per-requester handshake.
REQ-010 The block SHALL have ports m_axis_tdata, tkeep, tvalid, tlast and tuser as outputs, widths DATA_WIDTH, KEEP_WIDTH, 1, 1 and USER_WIDTH, feeding the shared FIFO adapter.
REQ-011 The block SHALL have port m_axis_tready, input, 1 bit, and port m_axis_tid, output, ID_WIDTH bits: the index of the granted port.

Function
REQ-012 The arbiter SHALL have two states: IDLE (no grant) and ACTIVE (grant held by one port).
REQ-013 In IDLE with any s_axis_tvalid set, the arbiter SHALL register grant = first set port searching from (last_grant+1) mod S_COUNT upward with wrap, record last_grant, and enter ACTIVE on the next cycle.
REQ-014 Arbitration latency SHALL be exactly 1 cycle from tvalid in IDLE to m_axis_tvalid.
REQ-015 In ACTIVE, the block SHALL drive m_axis_tdata, tkeep, tlast, tuser and tvalid combinationally from port grant, drive m_axis_tid = grant, and drive s_axis_tready[grant] = m_axis_tready; all other s_axis_tready bits SHALL be 0.
REQ-016 In IDLE, all s_axis_tready bits and m_axis_tvalid SHALL be 0.
REQ-017 The grant SHALL be held for a whole frame; ACTIVE to IDLE occurs only on a cycle with m_axis_tvalid & m_axis_tready & m_axis_tlast.
REQ-018 Back-to-back frames SHALL have one IDLE cycle between them; the re-arbitration in that cycle uses the updated last_grant.
REQ-019 A sole requester SHALL be re-granted after its own frame, with no starvation; with all ports requesting continuously, grants SHALL rotate 0,1,...,S_COUNT-1,0.
REQ-020 Deassertion of the granted port's tvalid mid-frame SHALL NOT release the grant; m_axis_tvalid follows it.
REQ-021 Stalls on m_axis_tready SHALL hold all outputs stable; no beat is lost or duplicated.

Reset
REQ-022 While rst=1, the block SHALL enter IDLE, set grant=0, set last_grant=S_COUNT-1 so the first search starts at port 0, and drive all s_axis_tready=0 and m_axis_tvalid=0.
REQ-023 Reset asserted mid-frame SHALL abandon the frame immediately, with no tlast emitted; the next grant follows REQ-013 from port 0.

Configuration
REQ-024 With macro AXIS_FRAME_RR_ARB_STATUS_EN defined, the block SHALL add output status_frame_count[15:0], reset to 0 and incremented on each completed output frame (tlast handshake), wrapping 0xFFFF to 0x0000.
REQ-025 With that macro defined, the block SHALL also add output status_busy, equal to 1 in ACTIVE.
REQ-026 Without AXIS_FRAME_RR_ARB_STATUS_EN defined, neither port nor its logic SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-027 Reset, then port 2 sends a 3-beat frame 0x11,0x22,0x33 with m_axis_tready=1 -> m_axis_tvalid rises 1 cycle after s_axis_tvalid[2], tid=2, 3 beats output, tlast on 0x33, then IDLE.
REQ-028 Ports 0-3 all hold 1-beat frames continuously -> output tid sequence 0,1,2,3,0 with one idle cycle between beats.
REQ-029 Port 1 granted mid 4-beat frame while port 0 is requesting -> no port-0 beat appears until port 1 tlast; next grant is 2 if requesting, else 0.
REQ-030 m_axis_tready toggles 1,0,0,1 during a 4-beat frame -> output beats in order, data stable during stalls, s_axis_tready[grant] mirrors m_axis_tready.
REQ-031 rst pulsed on beat 2 of a 5-beat frame from port 3, ports 0 and 3 requesting after -> outputs go to 0 the cycle after reset, and the first post-reset grant is port 0.
REQ-032 With STATUS_EN defined, 65537 single-beat frames -> status_frame_count=1.

Source files
------------

// File: rtl/axis_frame_rr_arb.sv
// Frame-granular round-robin arbiter: muxes S_COUNT AXI-Stream inputs onto one output, holding
// each grant for a whole frame. Optional status outputs under AXIS_FRAME_RR_ARB_STATUS_EN.
module axis_frame_rr_arb #(
    parameter int unsigned S_COUNT    = 4,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned USER_WIDTH = 1,
    parameter int unsigned ID_WIDTH   = $clog2(S_COUNT)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [S_COUNT*DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic [S_COUNT*KEEP_WIDTH-1:0]  s_axis_tkeep,
    input  logic [S_COUNT-1:0]             s_axis_tvalid,
    output logic [S_COUNT-1:0]             s_axis_tready,
    input  logic [S_COUNT-1:0]             s_axis_tlast,
    input  logic [S_COUNT*USER_WIDTH-1:0]  s_axis_tuser,
    output logic [DATA_WIDTH-1:0]          m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]          m_axis_tkeep,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tlast,
    output logic [USER_WIDTH-1:0]          m_axis_tuser,
    output logic [ID_WIDTH-1:0]            m_axis_tid
`ifdef AXIS_FRAME_RR_ARB_STATUS_EN
    ,
    output logic [15:0]                    status_frame_count,
    output logic                           status_busy
`endif
);

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    state_e              state_q, state_d;
    logic [ID_WIDTH-1:0] grant_q, grant_d;
    logic [ID_WIDTH-1:0] last_grant_q, last_grant_d;
    logic [ID_WIDTH-1:0] search_sel;
    logic                frame_done;

    // Pick the requester with the smallest rotational distance past last_grant.
    always_comb begin
        int unsigned best;
        int unsigned off;
        best       = S_COUNT;
        off        = 0;
        search_sel = '0;
        for (int i = 0; i < S_COUNT; i++) begin
            if (s_axis_tvalid[i]) begin
                off = (32'(i) + S_COUNT - 1 - 32'(last_grant_q)) % S_COUNT;
                if (off < best) begin
                    best       = off;
                    search_sel = ID_WIDTH'(i);
                end
            end
        end
    end

    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = '0;
        m_axis_tid    = '0;
        s_axis_tready = '0;
        if (state_q == StActive) begin
            m_axis_tid = grant_q;
            for (int i = 0; i < S_COUNT; i++) begin
                if (grant_q == ID_WIDTH'(i)) begin
                    m_axis_tdata     = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                    m_axis_tkeep     = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
                    m_axis_tuser     = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
                    m_axis_tvalid    = s_axis_tvalid[i];
                    m_axis_tlast     = s_axis_tlast[i];
                    s_axis_tready[i] = m_axis_tready;
                end
            end
        end
    end

    assign frame_done = m_axis_tvalid & m_axis_tready & m_axis_tlast;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            StIdle: begin
                if (|s_axis_tvalid) begin
                    grant_d      = search_sel;
                    last_grant_d = search_sel;
                    state_d      = StActive;
                end
            end
            StActive: begin
                if (frame_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_grant_q <= ID_WIDTH'(S_COUNT - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

`ifdef AXIS_FRAME_RR_ARB_STATUS_EN
    logic [15:0] frame_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_count_q <= '0;
        end else if (frame_done) begin
            frame_count_q <= frame_count_q + 16'd1;
        end
    end

    assign status_frame_count = frame_count_q;
    assign status_busy        = (state_q == StActive);
`endif

endmodule

// File: tb/tb_axis_frame_rr_arb.sv
// Directed bench for axis_frame_rr_arb (default build): table of per-cycle vectors plus a
// hand-written mid-frame reset sequence.
module tb_axis_frame_rr_arb;

    localparam int unsigned S_COUNT = 4;
    localparam int unsigned DW      = 64;
    localparam int unsigned KW      = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [S_COUNT*DW-1:0] s_tdata;
    logic [S_COUNT*KW-1:0] s_tkeep;
    logic [S_COUNT-1:0]    s_tvalid;
    logic [S_COUNT-1:0]    s_tready;
    logic [S_COUNT-1:0]    s_tlast;
    logic [S_COUNT-1:0]    s_tuser;
    logic [DW-1:0]         m_tdata;
    logic [KW-1:0]         m_tkeep;
    logic                  m_tvalid;
    logic                  m_tready;
    logic                  m_tlast;
    logic [0:0]            m_tuser;
    logic [1:0]            m_tid;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    axis_frame_rr_arb dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .s_axis_tuser  (s_tuser),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .m_axis_tuser  (m_tuser),
        .m_axis_tid    (m_tid)
    );

    typedef struct packed {
        logic        rst;
        logic [3:0]  vld;
        logic [3:0]  lst;
        logic [7:0]  dat;
        logic        rdy;
        logic        e_vld;
        logic [1:0]  e_tid;
        logic [63:0] e_data;
        logic        e_last;
        logic [3:0]  e_rdy;
    } vec_t;

    vec_t vecs[64];
    int   nvec = 0;

    task automatic add(input logic r, input logic [3:0] v, input logic [3:0] l,
                       input logic [7:0] d, input logic rd, input logic ev,
                       input logic [1:0] et, input logic [63:0] ed, input logic el,
                       input logic [3:0] er);
        vecs[nvec] = '{rst: r, vld: v, lst: l, dat: d, rdy: rd, e_vld: ev, e_tid: et,
                       e_data: ed, e_last: el, e_rdy: er};
        nvec++;
    endtask

    // Port i carries data {i, d}, keep 0xF0|i and user i[0].
    task automatic drive(input logic r, input logic [3:0] v, input logic [3:0] l,
                         input logic [7:0] d, input logic rd);
        rst      = r;
        s_tvalid = v;
        s_tlast  = l;
        m_tready = rd;
        for (int i = 0; i < S_COUNT; i++) begin
            s_tdata[i*DW +: DW] = {48'h0, 8'(i), d};
            s_tkeep[i*KW +: KW] = 8'hF0 | 8'(i);
            s_tuser[i]          = 1'(i & 1);
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        drive(1'b1, 4'b0, 4'b0, 8'h0, 1'b1);

        // Single 3-beat frame from port 2
        add(1, 4'b0000, 4'b0000, 8'h00, 1, 0, 0, 64'h0,   0, 4'b0000);
        add(0, 4'b0100, 4'b0000, 8'h11, 1, 0, 0, 64'h0,   0, 4'b0000);
        add(0, 4'b0100, 4'b0000, 8'h11, 1, 1, 2, 64'h211, 0, 4'b0100);
        add(0, 4'b0100, 4'b0000, 8'h22, 1, 1, 2, 64'h222, 0, 4'b0100);
        add(0, 4'b0100, 4'b0100, 8'h33, 1, 1, 2, 64'h233, 1, 4'b0100);
        add(0, 4'b0000, 4'b0000, 8'h00, 1, 0, 0, 64'h0,   0, 4'b0000);
        // All ports with 1-beat frames after reset: rotation 0,1,2,3,0
        add(1, 4'b1111, 4'b1111, 8'h55, 1, 0, 0, 64'h0,   0, 4'b0000);
        add(0, 4'b1111, 4'b1111, 8'h55, 1, 0, 0, 64'h0,   0, 4'b0000);
        add(0, 4'b1111, 4'b1111, 8'h55, 1, 1, 0, 64'h055, 1, 4'b0001);
        add(0, 4'b1111, 4'b1111, 8'h55, 1, 0, 0, 64'h0,   0, 4'b0000);
        add(0, 4'b1111, 4'b1111, 8'h55, 1, 1, 1, 64'h155, 1, 4'b0010);
        add(0, 4'b1111, 4'b1111, 8'h55, 1, 0, 0, 64'h0,   0, 4'b0000);
        add(0, 4'b1111, 4'b1111, 8'h55, 1, 1, 2, 64'h255, 1, 4'b0100);
        add(0, 4'b1111, 4'b1111, 8'h55, 1, 0, 0, 64'h0,   0, 4'b0000);
        add(0, 4'b1111, 4'b1111, 8'h55, 1, 1, 3, 64'h355, 1, 4'b1000);
        add(0, 4'b1111, 4'b1111, 8'h55, 1, 0, 0, 64'h0,   0, 4'b0000);
        add(0, 4'b1111, 4'b1111, 8'h55, 1, 1, 0, 64'h055, 1, 4'b0001);
        add(0, 4'b0000, 4'b0000, 8'h00, 1, 0, 0, 64'h0,   0, 4'b0000);
        // Port 1 holds a 4-beat frame while port 0 waits; then 2, then wrap to 0
        add(0, 4'b0011, 4'b0000, 8'h01, 1, 0, 0, 64'h0,   0, 4'b0000);
        add(0, 4'b0011, 4'b0000, 8'h01, 1, 1, 1, 64'h101, 0, 4'b0010);
        add(0, 4'b0011, 4'b0000, 8'h02, 1, 1, 1, 64'h102, 0, 4'b0010);
        add(0, 4'b0011, 4'b0000, 8'h03, 1, 1, 1, 64'h103, 0, 4'b0010);
        add(0, 4'b0011, 4'b0010, 8'h04, 1, 1, 1, 64'h104, 1, 4'b0010);
        add(0, 4'b0101, 4'b0000, 8'h07, 1, 0, 0, 64'h0,   0, 4'b0000);
        add(0, 4'b0101, 4'b0100, 8'h07, 1, 1, 2, 64'h207, 1, 4'b0100);
        add(0, 4'b0001, 4'b0001, 8'h08, 1, 0, 0, 64'h0,   0, 4'b0000);
        add(0, 4'b0001, 4'b0001, 8'h08, 1, 1, 0, 64'h008, 1, 4'b0001);
        add(0, 4'b0000, 4'b0000, 8'h00, 1, 0, 0, 64'h0,   0, 4'b0000);
        // Port 1 frame with ready stalls and a mid-frame tvalid gap
        add(0, 4'b0010, 4'b0000, 8'h0A, 1, 0, 0, 64'h0,   0, 4'b0000);
        add(0, 4'b0010, 4'b0000, 8'h0A, 1, 1, 1, 64'h10A, 0, 4'b0010);
        add(0, 4'b0010, 4'b0000, 8'h0B, 0, 1, 1, 64'h10B, 0, 4'b0000);
        add(0, 4'b0010, 4'b0000, 8'h0B, 0, 1, 1, 64'h10B, 0, 4'b0000);
        add(0, 4'b0010, 4'b0000, 8'h0B, 1, 1, 1, 64'h10B, 0, 4'b0010);
        add(0, 4'b0001, 4'b0000, 8'h0C, 1, 0, 0, 64'h0,   0, 4'b0010);
        add(0, 4'b0010, 4'b0000, 8'h0C, 1, 1, 1, 64'h10C, 0, 4'b0010);
        add(0, 4'b0010, 4'b0010, 8'h0D, 1, 1, 1, 64'h10D, 1, 4'b0010);
        add(0, 4'b0000, 4'b0000, 8'h00, 1, 0, 0, 64'h0,   0, 4'b0000);

        for (int k = 0; k < nvec; k++) begin
            @(negedge clk);
            drive(vecs[k].rst, vecs[k].vld, vecs[k].lst, vecs[k].dat, vecs[k].rdy);
            #1;
            chk($sformatf("v%0d tvalid", k), 64'(m_tvalid), 64'(vecs[k].e_vld));
            chk($sformatf("v%0d s_tready", k), 64'(s_tready), 64'(vecs[k].e_rdy));
            if (vecs[k].e_vld) begin
                chk($sformatf("v%0d tid", k), 64'(m_tid), 64'(vecs[k].e_tid));
                chk($sformatf("v%0d tdata", k), m_tdata, vecs[k].e_data);
                chk($sformatf("v%0d tlast", k), 64'(m_tlast), 64'(vecs[k].e_last));
            end
        end

        // Reset on beat 2 of a port-3 frame; next grant must start from port 0
        @(negedge clk); drive(1, 4'b0000, 4'b0000, 8'h00, 1);
        @(negedge clk); drive(0, 4'b1000, 4'b0000, 8'hA1, 1);
        #1 chk("rst idle tvalid", 64'(m_tvalid), 64'd0);
        @(negedge clk); drive(0, 4'b1000, 4'b0000, 8'hA1, 1);
        #1 chk("p3 beat1 tid", 64'(m_tid), 64'd3);
        chk("p3 beat1 tdata", m_tdata, 64'h3A1);
        chk("p3 beat1 tkeep", 64'(m_tkeep), 64'hF3);
        chk("p3 beat1 tuser", 64'(m_tuser), 64'd1);
        @(negedge clk); drive(1, 4'b1000, 4'b0000, 8'hA2, 1);
        #1 chk("p3 beat2 tvalid", 64'(m_tvalid), 64'd1);
        chk("p3 beat2 tdata", m_tdata, 64'h3A2);
        @(negedge clk); drive(0, 4'b1001, 4'b0000, 8'hB0, 1);
        #1 chk("post rst tvalid", 64'(m_tvalid), 64'd0);
        chk("post rst s_tready", 64'(s_tready), 64'd0);
        chk("post rst tlast", 64'(m_tlast), 64'd0);
        @(negedge clk); drive(0, 4'b1001, 4'b0001, 8'hB1, 1);
        #1 chk("post rst grant tvalid", 64'(m_tvalid), 64'd1);
        chk("post rst grant tid", 64'(m_tid), 64'd0);
        chk("post rst grant tdata", m_tdata, 64'h0B1);
        chk("post rst grant tkeep", 64'(m_tkeep), 64'hF0);
        chk("post rst grant s_tready", 64'(s_tready), 64'b0001);
        @(negedge clk); drive(0, 4'b0000, 4'b0000, 8'h00, 1);
        #1 chk("final idle tvalid", 64'(m_tvalid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
